// File: rtl/conv1d_mc_engine.sv
// Multi-channel strided 1-D convolution: serial signed MAC per output with bias,
// requantisation, ReLU/saturation, and a valid/ready result stream.
module conv1d_mc_engine #(
    parameter int N          = 512,
    parameter int K          = 32,
    parameter int STEP       = 8,
    parameter int CH         = 4,
    parameter int SHIFT      = 7,
    parameter int BIAS_SHIFT = 7
) (
    input  logic                                 clk,
    input  logic                                 global_rst,
    input  logic                                 ce,
    input  logic                                 start,
    output logic [$clog2(N)-1:0]                 act_addr,
    input  logic [7:0]                           act_rdata,
    output logic [$clog2(CH*K)-1:0]              wgt_addr,
    input  logic [7:0]                           wgt_rdata,
    output logic [$clog2(CH)-1:0]                bias_addr,
    input  logic [7:0]                           bias_rdata,
    output logic                                 mem_en,
    output logic [7:0]                           out_data,
    output logic [$clog2(CH)-1:0]                out_ch,
    output logic [$clog2((N-K)/STEP+1)-1:0]      out_idx,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic                                 busy,
    output logic                                 end_mod
);
    localparam int OUTLEN = (N - K) / STEP + 1;
    localparam int ACC_W  = 16 + $clog2(K) + 1;
    localparam int AW     = $clog2(N);
    localparam int WW     = $clog2(CH * K);
    localparam int CW     = $clog2(CH);
    localparam int OW     = $clog2(OUTLEN);
    localparam int KW     = $clog2(K);

    localparam logic [KW-1:0] K_LAST = KW'(K - 1);
    localparam logic [OW-1:0] O_LAST = OW'(OUTLEN - 1);
    localparam logic [CW-1:0] C_LAST = CW'(CH - 1);

    typedef enum logic [2:0] {S_IDLE, S_BIAS, S_MAC, S_DRAIN, S_OUT, S_DONE} state_t;

    state_t                   r_state;
    logic [CW-1:0]            r_ch;
    logic [OW-1:0]            r_o;
    logic [KW-1:0]            r_k;
    logic [AW-1:0]            r_abase;
    logic [WW-1:0]            r_wbase;
    logic signed [ACC_W-1:0]  r_acc;
    logic [AW-1:0]            r_act_addr;
    logic [WW-1:0]            r_wgt_addr;
    logic [CW-1:0]            r_bias_addr;
    logic [7:0]               r_out_data;
    logic [CW-1:0]            r_out_ch;
    logic [OW-1:0]            r_out_idx;
    logic                     r_out_valid;
    logic                     r_busy;
    logic                     r_end;

    logic signed [15:0]       w_prod;
    logic signed [ACC_W-1:0]  w_prod_x;
    logic signed [ACC_W-1:0]  w_bias_sh;
    logic signed [ACC_W-1:0]  w_acc_fin;
    logic signed [ACC_W-1:0]  w_req;
    logic [7:0]               w_sat;

    // Operands widened to 16 bits first; the full product always fits.
    assign w_prod    = $signed({{8{act_rdata[7]}}, act_rdata}) * $signed({{8{wgt_rdata[7]}}, wgt_rdata});
    assign w_prod_x  = {{(ACC_W-16){w_prod[15]}}, w_prod};
    assign w_bias_sh = {{(ACC_W-8){bias_rdata[7]}}, bias_rdata} <<< BIAS_SHIFT;
    assign w_acc_fin = r_acc + w_prod_x;
    assign w_req     = w_acc_fin >>> SHIFT;

    always_comb begin
        w_sat = '0;
        if (w_req[ACC_W-1])
            w_sat = '0;
        else if (|w_req[ACC_W-2:7])
            w_sat = 8'd127;
        else
            w_sat = w_req[7:0];
    end

    always_ff @(posedge clk or negedge global_rst) begin
        if (!global_rst) begin
            r_state     <= S_IDLE;
            r_ch        <= '0;
            r_o         <= '0;
            r_k         <= '0;
            r_abase     <= '0;
            r_wbase     <= '0;
            r_acc       <= '0;
            r_act_addr  <= '0;
            r_wgt_addr  <= '0;
            r_bias_addr <= '0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_out_idx   <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_end       <= 1'b0;
        end else if (ce) begin
            case (r_state)
                S_IDLE: if (start) begin
                    r_ch        <= '0;
                    r_o         <= '0;
                    r_k         <= '0;
                    r_abase     <= '0;
                    r_wbase     <= '0;
                    r_bias_addr <= '0;
                    r_busy      <= 1'b1;
                    r_state     <= S_BIAS;
                end
                S_BIAS: begin
                    r_k        <= '0;
                    r_act_addr <= r_abase;
                    r_wgt_addr <= r_wbase;
                    r_state    <= S_MAC;
                end
                S_MAC: begin
                    // ROM data lags the address by one cycle: tap k-1's product lands at tap k.
                    r_acc <= (r_k == '0) ? w_bias_sh : w_acc_fin;
                    if (r_k == K_LAST) begin
                        r_state <= S_DRAIN;
                    end else begin
                        r_k        <= r_k + 1'b1;
                        r_act_addr <= r_act_addr + 1'b1;
                        r_wgt_addr <= r_wgt_addr + 1'b1;
                    end
                end
                S_DRAIN: begin
                    r_out_data  <= w_sat;
                    r_out_ch    <= r_ch;
                    r_out_idx   <= r_o;
                    r_out_valid <= 1'b1;
                    r_state     <= S_OUT;
                end
                S_OUT: if (out_ready) begin
                    r_out_valid <= 1'b0;
                    if (r_o == O_LAST) begin
                        r_o     <= '0;
                        r_abase <= '0;
                        if (r_ch == C_LAST) begin
                            r_busy  <= 1'b0;
                            r_end   <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_ch        <= r_ch + 1'b1;
                            r_wbase     <= r_wbase + WW'(K);
                            r_bias_addr <= r_ch + 1'b1;
                            r_state     <= S_BIAS;
                        end
                    end else begin
                        r_o         <= r_o + 1'b1;
                        r_abase     <= r_abase + AW'(STEP);
                        r_bias_addr <= r_ch;
                        r_state     <= S_BIAS;
                    end
                end
                S_DONE: begin
                    r_end   <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign act_addr  = r_act_addr;
    assign wgt_addr  = r_wgt_addr;
    assign bias_addr = r_bias_addr;
    assign mem_en    = ce & r_busy;
    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;
    assign out_idx   = r_out_idx;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign end_mod   = r_end;
endmodule

// File: tb/tb_conv1d_mc_engine.sv
// Bench for conv1d_mc_engine: two instances (unshifted and default shifts) share
// stimulus; first-output vector table plus scoreboarded full-layer streams.
`timescale 1ns/1ps
module tb_conv1d_mc_engine;
    localparam int N = 512, K = 32, STEP = 8, CH = 4;
    localparam int OUTLEN = (N - K) / STEP + 1;
    localparam int NOUT   = CH * OUTLEN;
    localparam int AW = $clog2(N), WW = $clog2(CH * K), CW = $clog2(CH), OW = $clog2(OUTLEN);

    logic clk = 1'b0, rst_n = 1'b0, ce = 1'b0, start = 1'b0, ready = 1'b0;
    always #5 clk = ~clk;

    logic signed [7:0] act_mem [N];
    logic signed [7:0] wgt_mem [CH*K];
    logic signed [7:0] bias_mem [CH];

    logic [AW-1:0] a_act_addr, b_act_addr;
    logic [WW-1:0] a_wgt_addr, b_wgt_addr;
    logic [CW-1:0] a_bias_addr, b_bias_addr, a_ch, b_ch;
    logic [7:0]    a_act_rd, a_wgt_rd, a_bias_rd, b_act_rd, b_wgt_rd, b_bias_rd, a_data, b_data;
    logic [OW-1:0] a_idx, b_idx;
    logic a_mem_en, b_mem_en, a_valid, b_valid, a_busy, b_busy, a_end, b_end;

    conv1d_mc_engine #(.N(N), .K(K), .STEP(STEP), .CH(CH), .SHIFT(0), .BIAS_SHIFT(0)) u_a (
        .clk(clk), .global_rst(rst_n), .ce(ce), .start(start),
        .act_addr(a_act_addr), .act_rdata(a_act_rd), .wgt_addr(a_wgt_addr), .wgt_rdata(a_wgt_rd),
        .bias_addr(a_bias_addr), .bias_rdata(a_bias_rd), .mem_en(a_mem_en),
        .out_data(a_data), .out_ch(a_ch), .out_idx(a_idx), .out_valid(a_valid),
        .out_ready(ready), .busy(a_busy), .end_mod(a_end));

    conv1d_mc_engine #(.N(N), .K(K), .STEP(STEP), .CH(CH), .SHIFT(7), .BIAS_SHIFT(7)) u_b (
        .clk(clk), .global_rst(rst_n), .ce(ce), .start(start),
        .act_addr(b_act_addr), .act_rdata(b_act_rd), .wgt_addr(b_wgt_addr), .wgt_rdata(b_wgt_rd),
        .bias_addr(b_bias_addr), .bias_rdata(b_bias_rd), .mem_en(b_mem_en),
        .out_data(b_data), .out_ch(b_ch), .out_idx(b_idx), .out_valid(b_valid),
        .out_ready(ready), .busy(b_busy), .end_mod(b_end));

    // Synchronous ROMs with one-cycle read latency
    always @(posedge clk) if (a_mem_en) begin
        a_act_rd <= act_mem[a_act_addr]; a_wgt_rd <= wgt_mem[a_wgt_addr]; a_bias_rd <= bias_mem[a_bias_addr];
    end
    always @(posedge clk) if (b_mem_en) begin
        b_act_rd <= act_mem[b_act_addr]; b_wgt_rd <= wgt_mem[b_wgt_addr]; b_bias_rd <= bias_mem[b_bias_addr];
    end

    typedef struct { int ch; int idx; int data; } exp_t;
    typedef struct { int act; int wgt; int bias; int exp_a; int exp_b; } vec_t;

    exp_t qa[$], qb[$];
    vec_t vt[16];
    int tests = 0, fails = 0;

    task automatic chk(input string name, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    function automatic int sat(input int r);
        return (r < 0) ? 0 : ((r > 127) ? 127 : r);
    endfunction

    task automatic load_expect();
        qa.delete(); qb.delete();
        for (int c = 0; c < CH; c++)
            for (int o = 0; o < OUTLEN; o++) begin
                int s;
                s = 0;
                for (int k = 0; k < K; k++) s += int'(act_mem[o*STEP+k]) * int'(wgt_mem[c*K+k]);
                qa.push_back('{c, o, sat(s + int'(bias_mem[c]))});
                qb.push_back('{c, o, sat((s + int'(bias_mem[c]) * 128) >>> 7)});
            end
    endtask

    task automatic fill_uniform(input int a, input int w, input int b);
        for (int i = 0; i < N; i++) act_mem[i] = 8'(a);
        for (int i = 0; i < CH*K; i++) wgt_mem[i] = 8'(w);
        for (int i = 0; i < CH; i++) bias_mem[i] = 8'(b);
    endtask

    task automatic fill_random();
        int t;
        for (int i = 0; i < N; i++) begin t = int'($urandom_range(0, 8)) - 4; act_mem[i] = t[7:0]; end
        for (int i = 0; i < CH*K; i++) begin t = int'($urandom_range(0, 8)) - 4; wgt_mem[i] = t[7:0]; end
        for (int i = 0; i < CH; i++) begin t = int'($urandom_range(0, 255)) - 128; bias_mem[i] = t[7:0]; end
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    function automatic int outs_nonzero();
        return int'(|{a_data, a_ch, a_idx, a_valid, a_busy, a_end, a_act_addr, a_wgt_addr, a_bias_addr,
                      a_mem_en, b_data, b_valid, b_busy, b_end, b_mem_en});
    endfunction

    task automatic sb_check();
        exp_t e;
        if (ce && a_valid && ready) begin
            if (qa.size() == 0) chk("a_extra_output", 1, 0);
            else begin
                e = qa.pop_front();
                chk($sformatf("a_ch@%0d", qa.size()), int'(a_ch), e.ch);
                chk($sformatf("a_idx@%0d", qa.size()), int'(a_idx), e.idx);
                chk($sformatf("a_data(%0d,%0d)", e.ch, e.idx), int'(a_data), e.data);
            end
        end
        if (ce && b_valid && ready) begin
            if (qb.size() == 0) chk("b_extra_output", 1, 0);
            else begin
                e = qb.pop_front();
                chk($sformatf("b_ch@%0d", qb.size()), int'(b_ch), e.ch);
                chk($sformatf("b_idx@%0d", qb.size()), int'(b_idx), e.idx);
                chk($sformatf("b_data(%0d,%0d)", e.ch, e.idx), int'(b_data), e.data);
            end
        end
        if (!ce) chk("mem_en_while_ce0", int'(a_mem_en | b_mem_en), 0);
    endtask

    // One full layer run; optional random ce/ready, a 10-cycle stall on (1,7),
    // or an asynchronous reset when (2,30) is presented.
    task automatic run_stream(input string tag, input bit ce_rand, input bit rdy_rand,
                              input bit bp, input bit mid_rst, input bit chk_span);
        int n, hold, bad;
        bit bp_done, ended, hit;
        logic [7:0] s_data; logic [CW-1:0] s_ch; logic [OW-1:0] s_idx;
        logic [AW+WW+CW-1:0] s_addr;
        load_expect();
        @(posedge clk); #1 ce = 1'b1; ready = 1'b1; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        n = 0; hold = 0; bp_done = 0; ended = 0; hit = 0;
        while (n < 30000) begin
            @(negedge clk);
            if (a_end) begin ended = 1; break; end
            sb_check();
            if (hold > 0) begin
                chk({tag, "_stall_valid"}, int'(a_valid), 1);
                chk({tag, "_stall_data"}, int'(a_data), int'(s_data));
                chk({tag, "_stall_chidx"}, int'({a_ch, a_idx}), int'({s_ch, s_idx}));
                chk({tag, "_stall_addr"}, int'({a_act_addr, a_wgt_addr, a_bias_addr}), int'(s_addr));
            end
            @(posedge clk); #1;
            n++;
            ce = ce_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (mid_rst && a_valid && a_ch == 2 && a_idx == 30) begin
                hit = 1;
                rst_n = 1'b0;
                @(negedge clk);
                chk({tag, "_reset_outputs"}, outs_nonzero(), 0);
                chk({tag, "_pending_at_reset"}, qa.size(), NOUT - (2*OUTLEN + 30));
                @(posedge clk); #1 rst_n = 1'b1; ce = 1'b1;
                bad = 0;
                repeat (K + 10) begin @(negedge clk); bad += int'(a_end | b_end | a_busy | b_busy); end
                chk({tag, "_no_endmod_after_reset"}, bad, 0);
                break;
            end
            if (hold > 0) hold--;
            if (bp && !bp_done && a_valid && a_ch == 1 && a_idx == 7) begin
                bp_done = 1; hold = 10;
                s_data = a_data; s_ch = a_ch; s_idx = a_idx;
                s_addr = {a_act_addr, a_wgt_addr, a_bias_addr};
            end
            ready = (hold > 0) ? 1'b0 : (rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
        end
        if (mid_rst) begin
            chk({tag, "_reset_point_reached"}, int'(hit), 1);
        end else begin
            chk({tag, "_end_mod_seen"}, int'(ended), 1);
            chk({tag, "_b_end_aligned"}, int'(b_end), 1);
            chk({tag, "_a_remaining"}, qa.size(), 0);
            chk({tag, "_b_remaining"}, qb.size(), 0);
            if (bp) chk({tag, "_stall_applied"}, int'(bp_done), 1);
            // Inclusive of both the start cycle and the end_mod cycle
            if (chk_span) chk({tag, "_layer_cycles"}, n + 2, 1 + NOUT*(K+3) + 1);
            @(negedge clk);
            chk({tag, "_end_pulse_one_cycle"}, int'(a_end | a_busy), 0);
        end
        qa.delete(); qb.delete();
    endtask

    initial begin
        int n;
        vt[0]  = '{1,    1,    0,    32,  0};
        vt[1]  = '{1,   -1,    0,    0,   0};
        vt[2]  = '{0,    0,    5,    5,   5};
        vt[3]  = '{127,  127,  0,    127, 127};
        vt[4]  = '{-128, -128, 0,    127, 127};
        vt[5]  = '{-128, 127,  0,    0,   0};
        vt[6]  = '{2,    3,   -1,    127, 0};
        vt[7]  = '{1,    1,   -20,   12,  0};
        vt[8]  = '{10,   10,  -128,  127, 0};
        vt[9]  = '{1,    2,    1,    65,  1};
        vt[10] = '{1,    4,   -1,    127, 0};
        vt[11] = '{1,    1,    1,    33,  1};
        vt[12] = '{4,    1,    2,    127, 3};
        vt[13] = '{1,    1,    127,  127, 127};
        vt[14] = '{1,    1,    126,  127, 126};
        vt[15] = '{1,   -1,    1,    0,   0};

        fill_uniform(0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1 start = ~start; ce = 1'b1;
            @(negedge clk);
            chk($sformatf("reset_hold_outputs%0d", i), outs_nonzero(), 0);
        end
        #1 start = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("idle_busy_low", int'(a_busy | b_busy | a_mem_en), 0);
        end

        for (int i = 0; i < 16; i++) begin
            fill_uniform(vt[i].act, vt[i].wgt, vt[i].bias);
            do_reset();
            ready = 1'b0; ce = 1'b1;
            @(posedge clk); #1 start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
            n = 0;
            while (n < 200) begin
                @(negedge clk);
                if (a_valid) break;
                @(posedge clk); #1;
                n++;
            end
            chk($sformatf("vec%0d_latency", i), n, K + 2);
            chk($sformatf("vec%0d_a_data", i), int'(a_data), vt[i].exp_a);
            chk($sformatf("vec%0d_b_data", i), int'(b_data), vt[i].exp_b);
            chk($sformatf("vec%0d_first_chidx", i), int'({a_ch, a_idx}), 0);
        end

        fill_uniform(1, 1, 0);
        do_reset();
        run_stream("ramp", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        fill_random();
        run_stream("stall", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        run_stream("ce_toggle", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        fill_random();
        run_stream("midrst", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        run_stream("rerun", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/conv1d_mc_engine.md
# conv1d_mc_engine

Parametrised multi-channel 1-D strided convolution engine. It is the successor to the first conv layer: it generates real addresses into the synchronous input, weight and bias ROMs and runs a serial signed MAC per output. It then adds bias, requantises, applies ReLU and saturation, and streams one 8-bit result per output position per channel over a valid/ready port. It sits between the ROM/BRAM blocks and the next layer's buffer.

## Interface
- N, 512: input activation length (samples)
- K, 32: kernel length (taps)
- STEP, 8: stride
- CH, 4: output channel count
- SHIFT, 7: arithmetic right-shift applied to the accumulator before ReLU
- BIAS_SHIFT, 7: left-shift applied to the sign-extended bias before accumulation
- Localparams:
  - OUTLEN = (N-K)/STEP+1, which is 61 at the defaults
  - ACC_W = 16+$clog2(K)+1

- clk  in  1  rising-edge clock
- global_rst  in  1  asynchronous, active-low reset
- ce  in  1  clock enable; when low, all state freezes
- start  in  1  one-cycle start request, sampled in IDLE only
- act_addr  out  $clog2(N)  activation ROM address
- act_rdata  in  8  signed activation, valid 1 cycle after address
- wgt_addr  out  $clog2(CH*K)  weight ROM address; layout is ch*K+k
- wgt_rdata  in  8  signed weight, 1-cycle latency
- bias_addr  out  $clog2(CH)  bias ROM address
- bias_rdata  in  8  signed bias, 1-cycle latency
- mem_en  out  1  read enable for all ROMs; equals ce while busy
- out_data  out  8  result, range 0..127
- out_ch  out  $clog2(CH)  channel of out_data
- out_idx  out  $clog2(OUTLEN)  output position of out_data
- out_valid  out  1  result valid
- out_ready  in  1  downstream accept
- busy  out  1  high from the cycle after start until end_mod
- end_mod  out  1  one-cycle pulse after the last handshake

## Operation
- Loop order is channel outer, position middle, tap inner. Each result is acc(ch,o) = (sext(bias[ch]) << BIAS_SHIFT) + Σk act[o*STEP+k]*wgt[ch*K+k].
- FSM states: IDLE → BIAS → MAC → DRAIN → OUT → (BIAS | DONE) → IDLE.
  - IDLE: start=1 clears ch, o and k, then moves to BIAS.
  - BIAS: drive bias_addr=ch; go to MAC.
  - MAC: K cycles. Drive act_addr=o*STEP+k and wgt_addr=ch*K+k, with k counting 0..K-1.
    - On the first MAC cycle, load acc with the shifted bias.
    - On each later cycle, add the previous product.
  - DRAIN: add the last product. Register the requantised result into out_data and set out_valid=1.
  - OUT: hold out_data, out_ch, out_idx and out_valid until out_valid&out_ready.
    - On handshake, advance o. If o wraps past OUTLEN-1, reset o to 0 and advance ch.
    - If ch wraps past CH-1, go to DONE; otherwise go to BIAS.
  - DONE: pulse end_mod for one cycle, drop busy, return to IDLE.
- Arithmetic:
  - Products are full 16-bit signed.
  - acc is ACC_W bits signed and cannot overflow.
  - Requant r = acc >>> SHIFT (floor).
  - Output is out_data = 0 if r<0, 127 if r>127, else r[7:0].
- ce=0 freezes the FSM, counters, acc and outputs, and forces mem_en=0. The 1-cycle ROM pipeline stays aligned because the ROMs share the enable.
- start is ignored outside IDLE.
- out_ready is ignored outside OUT.

## Timing
- Reset values: out_data=0, out_ch=0, out_idx=0, out_valid=0, busy=0, end_mod=0, all addresses=0, mem_en=0. The state is IDLE.
- Reset has immediate effect mid-operation. Any in-flight result is discarded, and no end_mod pulse is produced.
- Per-output latency is measured from entry to BIAS (cycle 0):
  - The first MAC cycle is cycle 1.
  - DRAIN is cycle K+1.
  - out_valid is first high at cycle K+2.
- With out_ready held at 1 and ce held at 1:
  - Each output takes K+3 cycles.
  - The whole layer takes 1 + CH*OUTLEN*(K+3) + 1 cycles from start to end_mod, which is 8542 at the defaults.
- end_mod rises in the cycle after the final handshake.
- Backpressure: while out_valid=1 and out_ready=0, out_data, out_ch and out_idx do not change and no ROM address changes.

## Test plan
- Reset: hold global_rst=0 for 5 cycles while start toggles. All outputs stay at their reset values. Release reset; busy stays 0 until start.
- Ramp: act=1, wgt=1, bias=0, SHIFT=0, BIAS_SHIFT=0, ready=1.
  - 244 outputs, each with out_data=32.
  - out_ch/out_idx order is (0,0),(0,1)…(3,60).
  - end_mod is high exactly 8542 cycles after start.
- Signs: wgt=-1 with act=1 gives out_data=0 for every output (ReLU). Bias=5 with BIAS_SHIFT=0, SHIFT=0 and zero weights gives 5.
- Saturation: act=127, wgt=127, bias=0, SHIFT=7.
  - acc=516128, r=4032, so out_data=127.
- Backpressure and ce:
  - Hold out_ready=0 for 10 cycles on output (1,7): data is stable and there is no address change.
  - Toggle ce pseudo-randomly: the result stream is identical to the ce=1 stream.
- Mid-run reset at output (2,30): state returns to IDLE with no end_mod pulse. A new start produces the full correct 244-output sequence.
